// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus constants, sequencer state codes and mul/div load helper
// for the 5-stage core's central stall controller.
package pipe_stall_ctrl_pkg;

  localparam int   StallBus = 6;
  localparam logic Stop     = 1'b1;
  localparam logic NoStop   = 1'b0;

  typedef logic [StallBus-1:0] stall_t;

  // Bit k = 1 holds stage k; the first 0 above it receives a bubble.
  localparam stall_t STALL_MEM  = 6'b011111;
  localparam stall_t STALL_EX   = 6'b001111;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_IF   = 6'b000011;
  localparam stall_t STALL_NONE = 6'b000000;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  localparam int MD_CNT_W = 6;

  // Counter preload: the start cycle itself is one cycle of occupancy.
  function automatic logic [MD_CNT_W-1:0] md_load(input logic is_div,
                                                  input int   div_cycles,
                                                  input int   mul_cycles);
    int n;
    n = is_div ? div_cycles : mul_cycles;
    return MD_CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline <-> stall controller bundle: per-stage requests in, stall bus,
// flush, mul/div sequencing and performance counter out.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_stall_ctrl_pkg::*;

  logic             if_stallreq;
  logic             id_stallreq;
  logic             ex_md_req;
  logic             ex_md_is_div;
  logic             mem_stallreq;
  logic             excp_flush_req;

  stall_t           stall;
  logic             flush;
  logic             md_start;
  logic             md_done;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output if_stallreq, id_stallreq, ex_md_req, ex_md_is_div,
           mem_stallreq, excp_flush_req,
    input  stall, flush, md_start, md_done, md_busy, stall_cnt
  );

  modport slave (
    input  if_stallreq, id_stallreq, ex_md_req, ex_md_is_div,
           mem_stallreq, excp_flush_req,
    output stall, flush, md_start, md_done, md_busy, stall_cnt
  );

endinterface

// File: rtl/pipe_stall_ctrl_md_seq_fsm.sv
// IDLE/BUSY/DONE sequencer for the multi-cycle HI/LO mul/div unit in EX,
// with its occupancy counter and re-issue guard.
module md_seq_fsm
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 33,
  parameter int MUL_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic md_req_i,
  input  logic md_is_div_i,
  input  logic flush_i,
  input  logic hold_i,
  output logic md_start_o,
  output logic md_done_o,
  output logic md_busy_o,
  output logic ex_stall_o
);

  logic [1:0]          state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic                prev_done_q, prev_done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_start_o = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md_req_i && !prev_done_q) begin
          md_start_o = 1'b1;
          cnt_d      = md_load(md_is_div_i, DIV_CYCLES, MUL_CYCLES);
          state_d    = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // Leave when the decremented count reaches zero so DONE lands exactly
        // N cycles after the start pulse; memory stalls do not pause this.
        if (cnt_q <= MD_CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      MD_DONE: begin
        if (!hold_i) begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (flush_i) begin
      state_d    = MD_IDLE;
      cnt_d      = '0;
      md_start_o = 1'b0;
    end
  end

  assign prev_done_d = (state_q == MD_DONE) && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      prev_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_done_q <= prev_done_d;
    end
  end

  assign md_done_o  = (state_q == MD_DONE) && !flush_i;
  assign md_busy_o  = (state_q != MD_IDLE);
  assign ex_stall_o = (state_q == MD_BUSY) || ((state_q == MD_IDLE) && md_req_i);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline controller: priority-merges stage stall requests, applies
// exception flush, sequences mul/div and counts PC-stall cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 33,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 32
) (
  input logic            clk,
  input logic            rst,
  pipe_stall_ctrl_if.slave pipe_io
);

  logic       flush;
  logic       ex_stall;
  logic       md_start;
  logic       md_done;
  logic       md_busy;
  stall_t     stall_sel;
  stall_t     stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign flush = pipe_io.excp_flush_req;

  md_seq_fsm #(
    .DIV_CYCLES (DIV_CYCLES),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_md_seq (
    .clk         (clk),
    .rst         (rst),
    .md_req_i    (pipe_io.ex_md_req),
    .md_is_div_i (pipe_io.ex_md_is_div),
    .flush_i     (flush),
    .hold_i      (stall[3]),
    .md_start_o  (md_start),
    .md_done_o   (md_done),
    .md_busy_o   (md_busy),
    .ex_stall_o  (ex_stall)
  );

  always_comb begin
    stall_sel = STALL_NONE;
    if (pipe_io.mem_stallreq) begin
      stall_sel = STALL_MEM;
    end else if (ex_stall) begin
      stall_sel = STALL_EX;
    end else if (pipe_io.id_stallreq) begin
      stall_sel = STALL_ID;
    end else if (pipe_io.if_stallreq) begin
      stall_sel = STALL_IF;
    end
  end

  // A flush clears every stage register, so nothing may be held that cycle.
  assign stall = flush ? STALL_NONE : stall_sel;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall[0] == Stop) && !flush) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pipe_io.stall     = stall;
  assign pipe_io.flush     = flush;
  assign pipe_io.md_start  = md_start;
  assign pipe_io.md_done   = md_done;
  assign pipe_io.md_busy   = md_busy;
  assign pipe_io.stall_cnt = stall_cnt_q;

endmodule
